// File: rtl/nabp_projection_filter_if.sv
// Host-side stream, clear and coefficient-load bus of the projection ramp filter.
interface nabp_projection_filter_if #(
   parameter int DATA_LEN     = 8,
   parameter int FILTERED_LEN = 12,
   parameter int ORDER        = 16,
   parameter int COEF_LEN     = 12
);
   localparam int ADDR_LEN = $clog2(ORDER + 1);

   logic                           enable;
   logic                           clear;
   logic signed [DATA_LEN-1:0]     in_data;
   logic                           coef_wr_en;
   logic        [ADDR_LEN-1:0]     coef_addr;
   logic signed [COEF_LEN-1:0]     coef_data;
   logic signed [FILTERED_LEN-1:0] out_data;
   logic                           out_valid;

   modport master (
      output enable, clear, in_data, coef_wr_en, coef_addr, coef_data,
      input  out_data, out_valid
   );

   modport slave (
      input  enable, clear, in_data, coef_wr_en, coef_addr, coef_data,
      output out_data, out_valid
   );
endinterface

// File: rtl/nabp_projection_filter.sv
// Streaming symmetric-window FIR ramp filter feeding hs_val, one projection line per angle.
// Optional macro NABP_FILTER_SATURATE_EN clamps the output instead of wrapping it.
module nabp_projection_filter #(
   parameter int DATA_LEN     = 8,
   parameter int FILTERED_LEN = 12,
   parameter int ORDER        = 16,
   parameter int COEF_LEN     = 12,
   parameter int COEF_FRAC    = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   nabp_projection_filter_if.slave bus
);
   localparam int ADDR_LEN  = $clog2(ORDER + 1);
   localparam int ACC_LEN   = DATA_LEN + COEF_LEN + $clog2(ORDER + 1);
   localparam int FILL_MAX  = ORDER / 2 + 1;
   localparam int FILL_LEN  = $clog2(FILL_MAX + 1);

   localparam logic [ADDR_LEN-1:0]       LAST_ADDR  = ADDR_LEN'(ORDER);
   localparam logic [FILL_LEN-1:0]       FILL_FULL  = FILL_LEN'(FILL_MAX);
   localparam logic signed [ACC_LEN-1:0] ROUND_HALF = ACC_LEN'(2 ** (COEF_FRAC - 1));

   logic signed [COEF_LEN-1:0]     coef_q [0:ORDER];
   logic signed [DATA_LEN-1:0]     tap_p0 [0:ORDER];
   logic        [FILL_LEN-1:0]     fill_p0;
   logic                           en_p1;
   logic signed [ACC_LEN-1:0]      acc_p1;
   logic signed [FILTERED_LEN-1:0] out_data_p1;
   logic                           vld_p1;

   function automatic logic signed [ACC_LEN-1:0] round_half_up(input logic signed [ACC_LEN-1:0] acc);
      logic signed [ACC_LEN-1:0] biased;
      biased = acc + ROUND_HALF;
      return biased >>> COEF_FRAC;
   endfunction

`ifdef NABP_FILTER_SATURATE_EN
   localparam logic signed [ACC_LEN-1:0] SAT_HI = ACC_LEN'(2 ** (FILTERED_LEN - 1) - 1);
   localparam logic signed [ACC_LEN-1:0] SAT_LO = ACC_LEN'(-(2 ** (FILTERED_LEN - 1)));

   function automatic logic signed [FILTERED_LEN-1:0] narrow(input logic signed [ACC_LEN-1:0] val);
      if (val > SAT_HI)      return SAT_HI[FILTERED_LEN-1:0];
      else if (val < SAT_LO) return SAT_LO[FILTERED_LEN-1:0];
      else                   return val[FILTERED_LEN-1:0];
   endfunction
`else
   // Two's-complement wrap: only the low bits survive.
   function automatic logic signed [FILTERED_LEN-1:0] narrow(input logic signed [ACC_LEN-1:0] val);
      return val[FILTERED_LEN-1:0];
   endfunction
`endif

   // Stage p1: full-precision multiply-accumulate across the whole tap line.
   always_comb begin
      acc_p1 = '0;
      for (int k = 0; k <= ORDER; k++) begin
         acc_p1 = acc_p1 + (ACC_LEN'(coef_q[k]) * ACC_LEN'(tap_p0[k]));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k <= ORDER; k++) begin
            coef_q[k] <= '0;
            tap_p0[k] <= '0;
         end
         fill_p0     <= '0;
         en_p1       <= 1'b0;
         out_data_p1 <= '0;
         vld_p1      <= 1'b0;
      end else begin
         if (bus.coef_wr_en && (bus.coef_addr <= LAST_ADDR)) begin
            coef_q[bus.coef_addr] <= bus.coef_data;
         end

         if (bus.clear) begin
            for (int k = 0; k <= ORDER; k++) begin
               tap_p0[k] <= '0;
            end
            fill_p0     <= '0;
            en_p1       <= 1'b0;
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
         end else begin
            // Stage p0: accept a sample into the tap line.
            en_p1 <= bus.enable;
            if (bus.enable) begin
               tap_p0[0] <= bus.in_data;
               for (int k = ORDER; k > 0; k--) begin
                  tap_p0[k] <= tap_p0[k-1];
               end
               if (fill_p0 != FILL_FULL) begin
                  fill_p0 <= fill_p0 + 1'b1;
               end
            end

            // Stage p1: register the rounded, narrowed sum for the previous accepted sample.
            if (en_p1) begin
               out_data_p1 <= narrow(round_half_up(acc_p1));
               vld_p1      <= (fill_p0 >= FILL_FULL);
            end
         end
      end
   end

   assign bus.out_data  = out_data_p1;
   assign bus.out_valid = vld_p1;
endmodule
